// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a ROWS x COLS matrix keypad that has active-low rows and columns.
//   Each press is debounced and ghost patterns are rejected. A confirmed
//   press is queued as a key code in a small FIFO, and the CPU side pops
//   codes with a valid/ready handshake. All logic runs in the clk domain.
//   The scan rate comes from an internal clock-enable tick.
//
// Ports
//   clk       in   1        system clock
//   rst       in   1        synchronous active-high reset
//   row       in   ROWS     keypad rows, active-low, asynchronous to clk
//   col       out  COLS     column drive, active-low
//   ev_valid  out  1        event FIFO is non-empty
//   ev_ready  in   1        pops the head entry when ev_valid is also high
//   ev_code   out  CODE_W   head key code = row_idx*COLS + col_idx
//   key_held  out  1        a debounced key is currently down
//   overflow  out  1        sticky flag: a press was dropped because the FIFO was full
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CODE_W-1:0] ev_code,
  output logic              key_held,
  output logic              overflow
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int CIDX_W = $clog2(COLS);
  localparam int RIDX_W = $clog2(ROWS);
  localparam int ZCNT_W = $clog2(ROWS + 1);
  localparam int DCNT_W = $clog2(DEBOUNCE + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DEB, HELD} state_t;

  state_t              state;
  logic [ROWS-1:0]     row_meta;
  logic [ROWS-1:0]     rs;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [ZCNT_W-1:0]   zero_cnt;
  logic [RIDX_W-1:0]   rs_idx;
  logic                rs_valid;
  logic                rs_idle;
  logic [CIDX_W-1:0]   col_idx;
  logic [ROWS-1:0]     cand_row;
  logic [CODE_W-1:0]   cand_code;
  logic [CODE_W-1:0]   scan_code;
  logic [DCNT_W-1:0]   deb_cnt;
  logic [DCNT_W-1:0]   rel_cnt;
  logic                push;
  logic [CODE_W-1:0]   push_code;
  logic                pop;
  logic                push_ok;
  logic                full;
  logic                empty;
  logic [CODE_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CNT_W-1:0]    count;

  // Active-low one-hot column drive for the column under test.
  function automatic logic [COLS-1:0] col_drive(input logic [CIDX_W-1:0] idx);
    return ~(COLS'(1) << idx);
  endfunction

  // Two-flop synchroniser. It resets to all-ones, which reads as "no key".
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '1;
      rs       <= '1;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  assign tick = (tick_cnt == TICK_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Count the low rows. Exactly one low row is a usable press; two or more
  // low rows is treated as a ghost pattern.
  always_comb begin
    zero_cnt = '0;
    rs_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!rs[i]) begin
        zero_cnt = zero_cnt + ZCNT_W'(1);
        rs_idx   = RIDX_W'(i);
      end
    end
  end

  assign rs_valid  = (zero_cnt == ZCNT_W'(1));
  assign rs_idle   = &rs;
  assign scan_code = CODE_W'(rs_idx) * CODE_W'(COLS) + CODE_W'(col_idx);

  // The push fires on the same tick edge that moves the FSM into HELD,
  // so key_held and the FIFO write line up on one clock edge.
  always_comb begin
    push      = 1'b0;
    push_code = cand_code;
    if (tick) begin
      case (state)
        SCAN: if (rs_valid && DEBOUNCE == 1) begin
          push      = 1'b1;
          push_code = scan_code;
        end
        DEB: if (rs == cand_row && deb_cnt == DCNT_W'(DEBOUNCE - 1)) push = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      col_idx   <= '0;
      cand_row  <= '1;
      cand_code <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_held  <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rs_idle) begin
            state   <= SCAN;
            col_idx <= '0;
            col     <= col_drive('0);
          end
        end
        SCAN: begin
          if (rs_valid) begin
            cand_row  <= rs;
            cand_code <= scan_code;
            deb_cnt   <= DCNT_W'(1);
            if (DEBOUNCE == 1) begin
              state    <= HELD;
              key_held <= 1'b1;
              rel_cnt  <= '0;
            end else begin
              state <= DEB;
            end
          end else if (col_idx == CIDX_W'(COLS - 1)) begin
            state <= IDLE;
            col   <= '0;
          end else begin
            col_idx <= col_idx + CIDX_W'(1);
            col     <= col_drive(col_idx + CIDX_W'(1));
          end
        end
        DEB: begin
          if (rs == cand_row) begin
            if (deb_cnt == DCNT_W'(DEBOUNCE - 1)) begin
              state    <= HELD;
              key_held <= 1'b1;
              rel_cnt  <= '0;
            end else begin
              deb_cnt <= deb_cnt + DCNT_W'(1);
            end
          end else begin
            state <= IDLE;
            col   <= '0;
          end
        end
        HELD: begin
          // Only the tracked column is driven, so any low row here either
          // belongs to the held key or is ignored until the key is released.
          if (rs_idle) begin
            if (rel_cnt == DCNT_W'(DEBOUNCE - 1)) begin
              state    <= IDLE;
              key_held <= 1'b0;
              col      <= '0;
            end else begin
              rel_cnt <= rel_cnt + DCNT_W'(1);
            end
          end else begin
            rel_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = ev_ready && !empty;
  assign push_ok = push && (!full || pop);

  // When the FIFO is full, a push and a pop on the same edge reuse the slot
  // that the head is leaving (wr_ptr == rd_ptr in that case).
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign ev_valid = !empty;
  assign ev_code  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed testbench for keypad_scanner in a 4x4 setup with SCAN_DIV=4,
//   DEBOUNCE=3 and FIFO_DEPTH=4.
//   A behavioural keypad model pulls a row low whenever a pressed key sits
//   on a column that is currently driven low. Expected values are worked
//   out by hand from the scan and debounce timing.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          check_cnt = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_code(ev_code), .key_held(key_held),
    .overflow(overflow)
  );

  // Keypad matrix: key r*4+c connects row r to column c.
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  // Tracks the DUT tick phase: a scan tick lands on every edge where cyc%4==0.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Leaves the bench #1 after an edge on which a scan tick took effect.
  task automatic align_tick();
    step(1);
    while (cyc % 4 != 0) step(1);
  endtask

  task automatic wait_held(input logic val, input int budget, input string tag);
    int n = 0;
    while (key_held !== val && n < budget) begin
      step(1);
      n++;
    end
    check_output(tag, key_held, val);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (ev_valid !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check_output(tag, ev_valid, 1'b1);
  endtask

  task automatic apply_stimulus(input int code);
    align_tick();
    pressed[code] = 1'b1;
    wait_held(1'b1, 80, "press_held");
    pressed[code] = 1'b0;
    wait_held(1'b0, 60, "press_released");
    step(8);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
  endtask

  int exp5[4] = '{0, 5, 10, 15};
  int exp6[4] = '{7, 9, 14, 8};

  initial begin
    pressed  = '0;
    ev_ready = 1'b0;

    // Reset values
    apply_reset();
    check_output("rst_col", col, 4'h0);
    check_output("rst_valid", ev_valid, 1'b0);
    check_output("rst_code", ev_code, 4'h0);
    check_output("rst_held", key_held, 1'b0);
    check_output("rst_overflow", overflow, 1'b0);
    step(20);
    check_output("idle_col", col, 4'h0);

    // Single press of row1/col2, held steady
    align_tick();
    pressed[6] = 1'b1;
    wait_valid(60, "press6_valid");
    check_output("press6_code", ev_code, 4'd6);
    check_output("press6_held", key_held, 1'b1);
    check_output("press6_col", col, 4'b1011);
    pop_one();
    check_output("press6_popped", ev_valid, 1'b0);
    step(40);
    check_output("press6_no_repeat", ev_valid, 1'b0);
    check_output("press6_still_held", key_held, 1'b1);
    pressed[6] = 1'b0;
    step(8);
    check_output("release_debouncing", key_held, 1'b1);
    wait_held(1'b0, 40, "release_done");
    check_output("release_col", col, 4'h0);
    check_output("release_no_event", ev_valid, 1'b0);

    // Bounce: row1/col0 held low for only two ticks
    step(12);
    align_tick();
    pressed[4] = 1'b1;
    step(8);
    check_output("bounce_deb_col", col, 4'b1110);
    pressed[4] = 1'b0;
    step(5);
    check_output("bounce_idle_col", col, 4'h0);
    step(30);
    check_output("bounce_no_event", ev_valid, 1'b0);
    check_output("bounce_not_held", key_held, 1'b0);

    // Ghost: rows 0 and 2 both low on column 1
    align_tick();
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    step(13);
    check_output("ghost_col2", col, 4'b1011);
    step(4);
    check_output("ghost_col3", col, 4'b0111);
    step(4);
    check_output("ghost_idle", col, 4'h0);
    check_output("ghost_no_event", ev_valid, 1'b0);
    check_output("ghost_not_held", key_held, 1'b0);
    pressed[1] = 1'b0;
    pressed[9] = 1'b0;
    step(40);

    // Five presses with no consumer: the fifth is dropped
    apply_stimulus(0);
    apply_stimulus(5);
    apply_stimulus(10);
    apply_stimulus(15);
    check_output("fill_valid", ev_valid, 1'b1);
    check_output("fill_head", ev_code, 4'd0);
    check_output("fill_no_overflow", overflow, 1'b0);
    apply_stimulus(3);
    check_output("overflow_set", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_output("drain5_code", ev_code, exp5[i]);
      pop_one();
    end
    check_output("drain5_empty", ev_valid, 1'b0);
    check_output("overflow_sticky", overflow, 1'b1);

    // Full FIFO with a pop on the same edge as the push
    apply_reset();
    check_output("rst2_overflow", overflow, 1'b0);
    apply_stimulus(1);
    apply_stimulus(7);
    apply_stimulus(9);
    apply_stimulus(14);
    check_output("fill6_head", ev_code, 4'd1);
    align_tick();
    pressed[8] = 1'b1;
    step(15);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check_output("pushpop_held", key_held, 1'b1);
    check_output("pushpop_overflow", overflow, 1'b0);
    check_output("pushpop_valid", ev_valid, 1'b1);
    pressed[8] = 1'b0;
    wait_held(1'b0, 40, "pushpop_release");
    for (int i = 0; i < 4; i++) begin
      check_output("drain6_code", ev_code, exp6[i]);
      pop_one();
    end
    check_output("drain6_empty", ev_valid, 1'b0);
    check_output("drain6_overflow", overflow, 1'b0);

    // Reset in the middle of DEB with one event still queued
    apply_stimulus(2);
    check_output("queued_before_rst", ev_valid, 1'b1);
    align_tick();
    pressed[4] = 1'b1;
    step(13);
    check_output("middeb_col", col, 4'b1110);
    check_output("middeb_not_held", key_held, 1'b0);
    rst = 1'b1;
    pressed[4] = 1'b0;
    step(1);
    rst = 1'b0;
    check_output("middeb_rst_col", col, 4'h0);
    check_output("middeb_rst_valid", ev_valid, 1'b0);
    check_output("middeb_rst_code", ev_code, 4'h0);
    check_output("middeb_rst_held", key_held, 1'b0);
    check_output("middeb_rst_overflow", overflow, 1'b0);
    step(40);
    check_output("middeb_no_event", ev_valid, 1'b0);
    check_output("middeb_idle_col", col, 4'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
